// File: rtl/atconv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atconv_pkg
// Purpose  : Shared types, tap table and rounding helpers for the atrous
//            convolution / max-pool engine.
// Revision : 1.0
// ============================================================================
package atconv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WR_L0 = 3'd3,
        S_WR_L1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int NUM_TAPS = 9;
    localparam int LAST_TAP = NUM_TAPS - 1;

    // Offsets in units of the dilation; shift 0 is the +1 centre tap, the
    // others are subtracted after an arithmetic right shift.
    typedef struct packed {
        logic signed [1:0] drow;
        logic signed [1:0] dcol;
        logic        [2:0] shift;
    } tap_t;

    localparam tap_t TAP_TABLE [NUM_TAPS] = '{
        '{drow: 2'sb00, dcol: 2'sb00, shift: 3'd0},
        '{drow: 2'sb11, dcol: 2'sb11, shift: 3'd4},
        '{drow: 2'sb11, dcol: 2'sb00, shift: 3'd3},
        '{drow: 2'sb11, dcol: 2'sb01, shift: 3'd4},
        '{drow: 2'sb00, dcol: 2'sb11, shift: 3'd2},
        '{drow: 2'sb00, dcol: 2'sb01, shift: 3'd2},
        '{drow: 2'sb01, dcol: 2'sb11, shift: 3'd4},
        '{drow: 2'sb01, dcol: 2'sb00, shift: 3'd3},
        '{drow: 2'sb01, dcol: 2'sb01, shift: 3'd4}
    };

    function automatic int relu_sat(input int v, input int dw);
        int max_v;
        max_v = (1 << (dw - 1)) - 1;
        if (v < 0)
            return 0;
        if (v > max_v)
            return max_v;
        return v;
    endfunction

    function automatic int ceil_sat(input int v, input int fw, input int dw);
        int one;
        int max_v;
        int t;
        one   = 1 << fw;
        max_v = (1 << (dw - 1)) - one;
        t     = v & ~(one - 1);
        if ((v & (one - 1)) != 0)
            t = t + one;
        if (t > max_v)
            t = max_v;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool4_ceil.sv
`default_nettype none
// ============================================================================
// Module   : maxpool4_ceil
// Purpose  : Combinational 2x2 max followed by ceil-to-integer and clamp.
// Revision : 1.0
// ============================================================================
module maxpool4_ceil
    import atconv_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int FRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] slot0,
    input  logic signed [DATA_W-1:0] slot1,
    input  logic signed [DATA_W-1:0] slot2,
    input  logic signed [DATA_W-1:0] slot3,
    output logic signed [DATA_W-1:0] pooled
);

    logic signed [DATA_W-1:0] w_max01;
    logic signed [DATA_W-1:0] w_max23;
    logic signed [DATA_W-1:0] w_max;

    always_comb begin
        w_max01 = (slot0 > slot1) ? slot0 : slot1;
        w_max23 = (slot2 > slot3) ? slot2 : slot3;
        w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
        pooled  = DATA_W'(ceil_sat(32'(w_max), FRAC_W, DATA_W));
    end

endmodule
`default_nettype wire

// File: rtl/atconv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : atconv_pool_engine
// Purpose  : Dilated 3x3 sharpen with bias/ReLU to layer 0, optional 2x2
//            max-pool with ceil rounding to layer 1.
// Revision : 1.0
// ============================================================================
module atconv_pool_engine
    import atconv_pkg::*;
#(
    parameter int IMG_W_LOG2 = 6,
    parameter int DATA_W     = 13,
    parameter int FRAC_W     = 4,
    parameter int DIL        = 2,
    parameter int ADDR_W     = 2 * IMG_W_LOG2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic                     pool_en,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     busy,
    output logic                     done,
    output logic        [ADDR_W-1:0] iaddr,
    input  logic signed [DATA_W-1:0] idata,
    output logic                     cwr,
    output logic        [ADDR_W-1:0] caddr_wr,
    output logic        [DATA_W-1:0] cdata_wr,
    output logic                     csel
);

    localparam int ACC_W = DATA_W + 3;
    localparam int CW    = IMG_W_LOG2 + 2;
    localparam logic signed [CW-1:0] DIL_S = CW'(DIL);
    localparam logic signed [CW-1:0] MAX_S = CW'((1 << IMG_W_LOG2) - 1);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         pix_q, pix_d;
    logic [3:0]                tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      pool_en_q, pool_en_d;
    logic signed [DATA_W-1:0]  bias_q, bias_d;
    logic signed [DATA_W-1:0]  slot_q [4];
    logic signed [DATA_W-1:0]  slot_d [4];
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      cwr_q, cwr_d;
    logic                      csel_q, csel_d;
    logic [ADDR_W-1:0]         caddr_wr_q, caddr_wr_d;
    logic [DATA_W-1:0]         cdata_wr_q, cdata_wr_d;

    logic [IMG_W_LOG2-1:0]     w_row, w_col;
    logic                      w_last;
    logic [3:0]                w_dtap_idx;
    logic [2:0]                w_shift;
    logic signed [ACC_W-1:0]   w_pix_ext, w_term;
    logic signed [DATA_W-1:0]  w_result;
    logic signed [DATA_W-1:0]  w_pooled;

    function automatic logic [IMG_W_LOG2-1:0] clamp_coord(
        input logic [IMG_W_LOG2-1:0] base,
        input logic signed [1:0]     off
    );
        logic signed [CW-1:0] pos;
        pos = $signed({2'b00, base});
        if (off == 2'sb01)
            pos = pos + DIL_S;
        else if (off == 2'sb11)
            pos = pos - DIL_S;
        if (pos[CW-1])
            return '0;
        if (pos > MAX_S)
            return '1;
        return IMG_W_LOG2'(pos);
    endfunction

    // Pooled frames walk 2x2 blocks: pix = {block_row, block_col, sub_row, sub_col}.
    always_comb begin
        if (pool_en_q) begin
            w_row = {pix_q[ADDR_W-1:IMG_W_LOG2+1], pix_q[1]};
            w_col = {pix_q[IMG_W_LOG2:2], pix_q[0]};
        end else begin
            w_row = pix_q[ADDR_W-1:IMG_W_LOG2];
            w_col = pix_q[IMG_W_LOG2-1:0];
        end
        w_last = &pix_q;
        iaddr  = {clamp_coord(w_row, TAP_TABLE[tap_q].drow),
                  clamp_coord(w_col, TAP_TABLE[tap_q].dcol)};
    end

    // Read data trails the address by one cycle, so it belongs to the previous tap.
    always_comb begin
        w_dtap_idx = (state_q == S_FETCH && tap_q != 4'd0) ? tap_q - 4'd1 : tap_q;
        w_shift    = TAP_TABLE[w_dtap_idx].shift;
        w_pix_ext  = ACC_W'(idata);
        w_term     = (w_shift == 3'd0) ? w_pix_ext : -(w_pix_ext >>> w_shift);
        acc_d      = acc_q;
        if (state_q == S_FETCH && tap_q == 4'd0)
            acc_d = ACC_W'(bias_q);
        else if (state_q == S_FETCH || state_q == S_DRAIN)
            acc_d = acc_q + w_term;
        w_result   = DATA_W'(relu_sat(32'(acc_d), DATA_W));
    end

    maxpool4_ceil #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_pool (
        .slot0  (slot_q[0]),
        .slot1  (slot_q[1]),
        .slot2  (slot_q[2]),
        .slot3  (slot_q[3]),
        .pooled (w_pooled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            pool_en_q  <= 1'b0;
            bias_q     <= '0;
            slot_q     <= '{default: '0};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            pool_en_q  <= pool_en_d;
            bias_q     <= bias_d;
            slot_q     <= slot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        tap_d     = tap_q;
        pool_en_d = pool_en_q;
        bias_d    = bias_q;
        slot_d    = slot_q;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d   = S_FETCH;
                    pool_en_d = pool_en;
                    bias_d    = bias;
                    pix_d     = '0;
                    tap_d     = '0;
                end
            end
            S_FETCH: begin
                if (tap_q == 4'(LAST_TAP))
                    state_d = S_DRAIN;
                else
                    tap_d = tap_q + 4'd1;
            end
            S_DRAIN: begin
                state_d                = S_WR_L0;
                slot_d[pix_q[1:0]]     = w_result;
            end
            S_WR_L0, S_WR_L1: begin
                tap_d = '0;
                if (state_q == S_WR_L0 && pool_en_q && pix_q[1:0] == 2'b11) begin
                    state_d = S_WR_L1;
                    tap_d   = tap_q;
                end else if (w_last) begin
                    state_d = S_DONE;
                    pix_d   = '0;
                end else begin
                    state_d = S_FETCH;
                    pix_d   = pix_q + ADDR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        cwr_d      = 1'b0;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        if (state_q == S_DRAIN) begin
            cwr_d      = 1'b1;
            csel_d     = 1'b0;
            caddr_wr_d = {w_row, w_col};
            cdata_wr_d = w_result;
        end else if (state_q == S_WR_L0 && state_d == S_WR_L1) begin
            cwr_d      = 1'b1;
            csel_d     = 1'b1;
            caddr_wr_d = ADDR_W'(pix_q[ADDR_W-1:2]);
            cdata_wr_d = w_pooled;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_atconv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_atconv_pool_engine
// Purpose  : Self-checking bench for atconv_pool_engine on a 16x16 image.
// Revision : 1.0
// ============================================================================
module tb_atconv_pool_engine;

    localparam int IMG_W_LOG2 = 4;
    localparam int DATA_W     = 13;
    localparam int FRAC_W     = 4;
    localparam int DIL        = 2;
    localparam int ADDR_W     = 2 * IMG_W_LOG2;
    localparam int IMG_W      = 1 << IMG_W_LOG2;
    localparam int NPIX       = IMG_W * IMG_W;
    localparam int NBLK       = NPIX / 4;
    localparam int RES_MAX    = (1 << (DATA_W - 1)) - 1;
    localparam int POOL_MAX   = (1 << (DATA_W - 1)) - (1 << FRAC_W);
    localparam int CYC_LIMIT  = 4000;

    logic              clk = 1'b0;
    logic              reset;
    logic              ready;
    logic              pool_en;
    logic [DATA_W-1:0] bias;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] idata;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic              csel;

    logic [DATA_W-1:0] mem [NPIX];
    int                exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    atconv_pool_engine #(
        .IMG_W_LOG2 (IMG_W_LOG2),
        .DATA_W     (DATA_W),
        .FRAC_W     (FRAC_W),
        .DIL        (DIL),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .pool_en  (pool_en),
        .bias     (bias),
        .busy     (busy),
        .done     (done),
        .iaddr    (iaddr),
        .idata    (idata),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) idata <= mem[iaddr];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int pix_at(input int r, input int c);
        int rr;
        int cc;
        rr = (r < 0) ? 0 : (r > IMG_W - 1) ? IMG_W - 1 : r;
        cc = (c < 0) ? 0 : (c > IMG_W - 1) ? IMG_W - 1 : c;
        return int'($signed(mem[rr * IMG_W + cc]));
    endfunction

    function automatic int conv_ref(input int r, input int c, input int b);
        int acc;
        acc = b;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int x;
                x = pix_at(r + dr * DIL, c + dc * DIL);
                if (dr == 0 && dc == 0)
                    acc += x;
                else
                    acc -= x >>> ((dr == 0) ? 2 : (dc == 0) ? 3 : 4);
            end
        end
        if (acc < 0)
            return 0;
        return (acc > RES_MAX) ? RES_MAX : acc;
    endfunction

    function automatic int ceil_ref(input int m);
        int rem;
        int t;
        rem = m % (1 << FRAC_W);
        t   = (rem == 0) ? m : m - rem + (1 << FRAC_W);
        return (t > POOL_MAX) ? POOL_MAX : t;
    endfunction

    function automatic int pack_wr(input int s, input int a, input int d);
        return (s << 20) | (a << 13) | d;
    endfunction

    task automatic build_expected(input bit pe, input int b);
        exp_q.delete();
        if (pe) begin
            for (int br = 0; br < IMG_W / 2; br++) begin
                for (int bc = 0; bc < IMG_W / 2; bc++) begin
                    int mx;
                    mx = 0;
                    for (int s = 0; s < 4; s++) begin
                        int r;
                        int c;
                        int v;
                        r = 2 * br + s / 2;
                        c = 2 * bc + s % 2;
                        v = conv_ref(r, c, b);
                        exp_q.push_back(pack_wr(0, r * IMG_W + c, v));
                        if (v > mx) mx = v;
                    end
                    exp_q.push_back(pack_wr(1, br * (IMG_W / 2) + bc, ceil_ref(mx)));
                end
            end
        end else begin
            for (int r = 0; r < IMG_W; r++)
                for (int c = 0; c < IMG_W; c++)
                    exp_q.push_back(pack_wr(0, r * IMG_W + c, conv_ref(r, c, b)));
        end
    endtask

    task automatic run_frame(input string name, input bit pe, input int b);
        int cyc;
        int got;
        bit seen;
        int exp_cycles;
        build_expected(pe, b);
        exp_cycles = NPIX * 11 + (pe ? NBLK : 0);
        @(negedge clk);
        ready   = 1'b1;
        pool_en = pe;
        bias    = DATA_W'(b);
        @(posedge clk);
        #1;
        ready   = 1'b0;
        pool_en = ~pe;
        bias    = ~bias;
        cyc  = 0;
        got  = 0;
        seen = 1'b0;
        while (!seen && cyc < CYC_LIMIT) begin
            @(negedge clk);
            if (cyc == 0)
                check_eq({name, ":busy_first"}, busy, 1);
            if (cwr) begin
                if (got < exp_q.size())
                    check_eq($sformatf("%s:wr%0d", name, got),
                             pack_wr(csel, caddr_wr, cdata_wr), exp_q[got]);
                got++;
            end
            if (done)
                seen = 1'b1;
            else
                cyc++;
        end
        check_eq({name, ":done_seen"}, seen, 1);
        check_eq({name, ":done_cycle"}, cyc, exp_cycles);
        check_eq({name, ":wr_count"}, got, exp_q.size());
        check_eq({name, ":busy_at_done"}, busy, 0);
        @(negedge clk);
        check_eq({name, ":done_pulse"}, done, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'($urandom);
    endtask

    initial begin
        int b;
        int wr_seen;
        reset   = 1'b1;
        ready   = 1'b0;
        pool_en = 1'b0;
        bias    = '0;
        fill_const(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst:busy", busy, 0);
        check_eq("rst:done", done, 0);
        check_eq("rst:cwr", cwr, 0);
        check_eq("rst:csel", csel, 0);
        check_eq("rst:iaddr", iaddr, 0);
        check_eq("rst:caddr", caddr_wr, 0);
        check_eq("rst:cdata", cdata_wr, 0);

        fill_const('h100);
        run_frame("const", 1'b1, -12);

        fill_const(0);
        mem[10 * IMG_W + 10] = 'h100;
        run_frame("imp", 1'b1, -12);
        run_frame("imp_b0", 1'b1, 0);

        fill_const(0);
        mem[0] = 'h40;
        run_frame("corner", 1'b1, -12);

        fill_random();
        b = $urandom_range(0, 512) - 256;
        run_frame("rnd_raster", 1'b0, b);

        for (int k = 0; k < 2; k++) begin
            fill_random();
            b = $urandom_range(0, 512) - 256;
            run_frame($sformatf("rnd_pool%0d", k), 1'b1, b);
        end

        for (int r = 0; r < IMG_W; r++)
            for (int c = 0; c < IMG_W; c++)
                mem[r * IMG_W + c] = (r == 0 || c == 0 || r == IMG_W - 1 || c == IMG_W - 1)
                                     ? DATA_W'('h1000) : DATA_W'('h0FFF);
        run_frame("sat", 1'b1, 'h0FF0);

        fill_random();
        @(negedge clk);
        ready   = 1'b1;
        pool_en = 1'b1;
        bias    = '0;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort:busy", busy, 0);
        check_eq("abort:cwr", cwr, 0);
        check_eq("abort:done", done, 0);
        reset   = 1'b0;
        wr_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (cwr || busy) wr_seen++;
        end
        check_eq("abort:quiet", wr_seen, 0);
        run_frame("restart", 1'b1, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
